// File: rtl/text_pkg.sv
// text_pkg: shared glyph geometry, ROM address width and renderer FSM states
package text_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int ROM_AW  = 8;
  typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;
endpackage

// File: rtl/glyph_shifter.sv
// glyph_shifter: glyph row load/shift register with pixel bit counter
//   Clk, Reset_n : clock, synchronous active-low reset
//   i_load       : load i_data and clear the bit counter (wins over i_shift)
//   i_shift      : shift left one pixel and advance the bit counter
//   o_msb        : pixel currently at the left edge of the row
//   o_bit        : index of that pixel within the glyph row
module glyph_shifter import text_pkg::*; (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [GLYPH_W-1:0] i_data,
  output logic               o_msb,
  output logic [2:0]         o_bit
);
  logic [GLYPH_W-1:0] r_sh;
  logic [2:0]         r_bit;
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      r_sh  <= '0;
      r_bit <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_bit <= '0;
    end else if (i_shift) begin
      r_sh  <= r_sh << 1;
      r_bit <= r_bit + 3'd1;
    end
  assign o_msb = r_sh[GLYPH_W-1];
  assign o_bit = r_bit;
endmodule

// File: rtl/score_text_renderer.sv
// score_text_renderer: streams "SCORE:" glyph ROM rows into a per-pixel text_on mask
//   Clk, Reset_n : clock, synchronous active-low reset
//   pixel_en     : one-cycle pixel strobe; all state advances only on it
//   DrawX, DrawY : raster position of the pixel presented with pixel_en
//   rom_addr     : registered glyph ROM address (glyph*16 + row)
//   rom_data     : ROM row for rom_addr, bit 7 = leftmost pixel
//   text_on      : lit flag for the pixel of the previous strobe
//   busy         : FSM is prefetching or rendering
module score_text_renderer import text_pkg::*; #(
  parameter int TEXT_X     = 16,
  parameter int TEXT_Y     = 8,
  parameter int NUM_GLYPHS = 6
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pixel_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic              text_on,
  output logic              busy
);
  localparam logic [9:0] X_PRE   = 10'(TEXT_X - 2);
  localparam logic [9:0] X_LOAD  = 10'(TEXT_X - 1);
  localparam logic [9:0] X_START = 10'(TEXT_X);
  localparam logic [9:0] Y_TOP   = 10'(TEXT_Y);
  localparam logic [9:0] Y_END   = 10'(TEXT_Y + GLYPH_H);
  localparam logic [3:0] LAST_G  = 4'(NUM_GLYPHS - 1);
  state_t            r_state, w_state_nx;
  logic [3:0]        r_glyph, w_glyph_nx;
  logic [9:0]        r_exp_x, w_exp_nx;
  logic [ROM_AW-1:0] r_addr, w_addr_nx;
  logic              r_text, w_text_nx;
  logic              w_load, w_shift, w_msb, w_in_band, w_more;
  logic [2:0]        w_bit;
  logic [3:0]        w_row;
  assign w_in_band = (DrawY >= Y_TOP) && (DrawY < Y_END);
  assign w_row     = 4'(DrawY - Y_TOP);
  assign w_more    = r_glyph < LAST_G;
  glyph_shifter u_shifter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (rom_data),
    .o_msb   (w_msb),
    .o_bit   (w_bit)
  );
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      r_state <= IDLE;
      r_glyph <= '0;
      r_exp_x <= '0;
      r_addr  <= '0;
      r_text  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_glyph <= w_glyph_nx;
      r_exp_x <= w_exp_nx;
      r_addr  <= w_addr_nx;
      r_text  <= w_text_nx;
    end
  // The next glyph's address is issued at bit 0 so its row is settled on
  // rom_data by bit 7, when it is loaded seamlessly behind the current one.
  always_comb begin
    w_state_nx = r_state;
    w_glyph_nx = r_glyph;
    w_exp_nx   = r_exp_x;
    w_addr_nx  = r_addr;
    w_text_nx  = r_text;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    if (pixel_en)
      case (r_state)
        IDLE: begin
          w_text_nx = 1'b0;
          if (w_in_band && DrawX == X_PRE) begin
            w_addr_nx  = {4'd0, w_row};
            w_glyph_nx = '0;
            w_state_nx = PREFETCH;
          end
        end
        PREFETCH: begin
          w_text_nx  = 1'b0;
          w_load     = DrawX == X_LOAD;
          w_exp_nx   = w_load ? X_START : r_exp_x;
          w_state_nx = w_load ? ACTIVE : IDLE;
        end
        ACTIVE: begin
          if (DrawX != r_exp_x || !w_in_band) begin
            w_text_nx  = 1'b0;
            w_state_nx = IDLE;
          end else begin
            w_text_nx = w_msb;
            w_shift   = 1'b1;
            w_exp_nx  = r_exp_x + 10'd1;
            if (w_bit == 3'd0 && w_more)
              w_addr_nx = {r_glyph + 4'd1, w_row};
            if (w_bit == 3'd7) begin
              w_load     = w_more;
              w_glyph_nx = w_more ? r_glyph + 4'd1 : r_glyph;
              w_state_nx = w_more ? ACTIVE : IDLE;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
  end
  assign rom_addr = r_addr;
  assign text_on  = r_text;
  assign busy     = r_state != IDLE;
endmodule
